barrel_shift_register: RTL and testbench

Loadable 16-bit barrel shift register. Captures an 8-bit word, zero-extended, into an internal register. Every cycle it presents that word shifted or rotated by a runtime amount (0–15) in a runtime direction on a registered 16-bit output. Used as a datapath shifter stage: stored operand in, one-cycle-latency shifted result out.

---
 rtl/bsr_pkg.sv | 11 +
 rtl/barrel_shifter_core.sv | 33 +++
 rtl/barrel_shift_register.sv | 43 ++++
 tb/tb_barrel_shift_register.sv | 134 +++++++++++++
 4 files changed

// File: rtl/bsr_pkg.sv
// bsr_pkg: shared widths and direction encoding for the barrel shift register.
package bsr_pkg;
    localparam int DATA_W  = 8;
    localparam int OUT_W   = 16;
    localparam int SHAMT_W = 4;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;
endpackage

// File: rtl/barrel_shifter_core.sv
// barrel_shifter_core: combinational log2(OUT_W)-stage shifter; BSR_ROTATE_EN selects rotate
// over logical zero-fill shift.
module barrel_shifter_core
    import bsr_pkg::DIR_RIGHT;
#(
    parameter int OUT_W   = bsr_pkg::OUT_W,
    parameter int SHAMT_W = bsr_pkg::SHAMT_W
) (
    input  logic [OUT_W-1:0]   word,
    input  logic [SHAMT_W-1:0] amount,
    input  logic               direction,
    output logic [OUT_W-1:0]   result
);
    logic [OUT_W-1:0] r;
    logic [OUT_W-1:0] l;

    // stage s moves by 2**s when amount bit s is set
    always_comb begin
        result = word;
        r = '0;
        l = '0;
        for (int s = 0; s < SHAMT_W; s++) begin
`ifdef BSR_ROTATE_EN
            r = (result >> (1 << s)) | (result << (OUT_W - (1 << s)));
            l = (result << (1 << s)) | (result >> (OUT_W - (1 << s)));
`else
            r = result >> (1 << s);
            l = result << (1 << s);
`endif
            result = amount[s] ? ((direction == DIR_RIGHT) ? r : l) : result;
        end
    end
endmodule

// File: rtl/barrel_shift_register.sv
// barrel_shift_register: loadable word with one-cycle registered shift/rotate output.
// Rotate instead of zero-fill shift when BSR_ROTATE_EN is defined.
module barrel_shift_register #(
    parameter int DATA_W  = bsr_pkg::DATA_W,
    parameter int OUT_W   = bsr_pkg::OUT_W,
    parameter int SHAMT_W = bsr_pkg::SHAMT_W
) (
    input  logic               i_clk,
    input  logic               i_res_n,
    input  logic               i_load,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_direction_right,
    input  logic [SHAMT_W-1:0] i_shift_emount,
    output logic [OUT_W-1:0]   o_out
);
    logic [OUT_W-1:0] data_reg;
    logic [OUT_W-1:0] out_reg;
    logic [OUT_W-1:0] shifted;
    logic [OUT_W-1:0] loaded;

    assign loaded = OUT_W'(i_data);
    assign o_out  = out_reg;

    barrel_shifter_core #(.OUT_W(OUT_W), .SHAMT_W(SHAMT_W)) u_core (
        .word      (data_reg),
        .amount    (i_shift_emount),
        .direction (i_direction_right),
        .result    (shifted)
    );

    // shift always reads data_reg, never out_reg, so results do not accumulate
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            data_reg <= '0;
            out_reg  <= '0;
        end else if (i_load) begin
            data_reg <= loaded;
            out_reg  <= loaded;
        end else begin
            out_reg  <= shifted;
        end
    end
endmodule

// File: tb/tb_barrel_shift_register.sv
// tb_barrel_shift_register: directed scoreboard bench; golden bit-index model covers both
// BSR_ROTATE_EN builds.
module tb_barrel_shift_register;
    logic        i_clk = 1'b0;
    logic        i_res_n;
    logic        i_load;
    logic [7:0]  i_data;
    logic        i_direction_right;
    logic [3:0]  i_shift_emount;
    logic [15:0] o_out;

    logic [15:0] exp_q[$];
    logic [15:0] model_data;
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    barrel_shift_register dut (
        .i_clk             (i_clk),
        .i_res_n           (i_res_n),
        .i_load            (i_load),
        .i_data            (i_data),
        .i_direction_right (i_direction_right),
        .i_shift_emount    (i_shift_emount),
        .o_out             (o_out)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] model(input logic [15:0] w, input logic [3:0] n,
                                          input logic right);
        logic [15:0] r;
        int src;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            src = right ? i + int'(n) : i - int'(n);
`ifdef BSR_ROTATE_EN
            r[i] = w[(src + 16) % 16];
`else
            if (src >= 0 && src < 16) r[i] = w[src];
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic ld, input logic [7:0] d,
                        input logic dr, input logic [3:0] a);
        i_load = ld;
        i_data = d;
        i_direction_right = dr;
        i_shift_emount = a;
        exp_q.push_back(ld ? {8'h00, d} : model(model_data, a, dr));
        if (ld) model_data = {8'h00, d};
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0) check({tag, "_empty"}, o_out, 16'hxxxx);
        else check(tag, o_out, exp_q.pop_front());
    endtask

    initial begin
        i_res_n = 1'b0;
        i_load = 1'b1;
        i_data = 8'h35;
        i_direction_right = 1'b1;
        i_shift_emount = 4'd0;
        model_data = '0;
        #1;
        check("reset_async", o_out, 16'h0000);
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk);
            #1;
            check("reset_hold", o_out, 16'h0000);
        end
        #3 i_res_n = 1'b1;
        step("load_35", 1'b1, 8'h35, 1'b1, 4'd0);
        check("load_const", o_out, 16'h0035);
        step("run_r0", 1'b0, 8'h35, 1'b1, 4'd0);
        check("r0_const", o_out, 16'h0035);

`ifdef BSR_ROTATE_EN
        step("rot_r1", 1'b0, 8'h35, 1'b1, 4'd1);
        check("rot_r1_const", o_out, 16'h801A);
        step("rot_r4", 1'b0, 8'h35, 1'b1, 4'd4);
        check("rot_r4_const", o_out, 16'h5003);
        step("rot_l4", 1'b0, 8'h35, 1'b0, 4'd4);
        check("rot_l4_const", o_out, 16'h0350);
        step("rot_l15", 1'b0, 8'h35, 1'b0, 4'd15);
        check("rot_l15_const", o_out, 16'h801A);
`else
        step("shf_r1", 1'b0, 8'h35, 1'b1, 4'd1);
        check("shf_r1_const", o_out, 16'h001A);
        step("shf_r8", 1'b0, 8'h35, 1'b1, 4'd8);
        check("shf_r8_const", o_out, 16'h0000);
        step("shf_l12", 1'b0, 8'h35, 1'b0, 4'd12);
        check("shf_l12_const", o_out, 16'h5000);
        step("shf_l15", 1'b0, 8'h35, 1'b0, 4'd15);
        check("shf_l15_const", o_out, 16'h8000);
`endif

        step("load_a5c3", 1'b1, 8'hC3, 1'b0, 4'd7);
        for (int d = 1; d >= 0; d--)
            for (int n = 0; n < 16; n++)
                for (int h = 0; h < 5; h++)
                    step(d ? "sweep_r" : "sweep_l", 1'b0, 8'hC3, d[0], n[3:0]);

        step("data_ignored", 1'b0, 8'hFF, 1'b0, 4'd3);
        step("load_ff", 1'b1, 8'hFF, 1'b0, 4'd3);
        check("load_ff_const", o_out, 16'h00FF);
        step("ff_l3", 1'b0, 8'hFF, 1'b0, 4'd3);
        step("ff_r5", 1'b0, 8'hFF, 1'b1, 4'd5);

        #3 i_res_n = 1'b0;
        #1 check("reset_mid", o_out, 16'h0000);
        model_data = '0;
        @(posedge i_clk);
        #1 check("reset_mid_hold", o_out, 16'h0000);
        #3 i_res_n = 1'b1;
        step("lost_word", 1'b0, 8'h5A, 1'b0, 4'd2);
        step("reload", 1'b1, 8'h5A, 1'b0, 4'd2);
        step("reload_l2", 1'b0, 8'h5A, 1'b0, 4'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
